fifo_rr_arbiter: RTL and testbench
==================================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, giving the number of FWFT FIFO sources; legal range 2..16, not necessarily a power of 2.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-003 The block SHALL have parameter MAX_BURST, default 1, giving the max consecutive grants to one source before priority rotates; legal range 1..255.
REQ-004 The block SHALL define localparam SW = max(1, $clog2(NUM_SRC)).
REQ-005 clk  input  1  the single clock; all state updates on posedge clk.
REQ-006 srst  input  1  synchronous, active-high reset.
REQ-007 in_empty  input  NUM_SRC  per-source FIFO empty flag; bit i low means in_dout slice i is valid (first-word fall-through).
REQ-008 in_dout  input  NUM_SRC*WIDTH  concatenated FIFO head data; source i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_rd_en  output  NUM_SRC  per-source pop strobe, one-hot or zero.
REQ-010 out_valid  output  1  merged stream valid.
REQ-011 out_data  output  WIDTH  merged stream data.
REQ-012 out_src  output  SW  index of the source that out_data came from.
REQ-013 out_ready  input  1  downstream accept; a transfer occurs when out_valid & out_ready.

Function
REQ-014 The output stage SHALL be one register holding out_valid, out_data and out_src; load_en = !out_valid | out_ready.
REQ-015 When load_en is high and at least one in_empty bit is low, the block SHALL grant source g: the first non-empty index searched from ptr upward, modulo NUM_SRC.
REQ-016 On a grant, in_rd_en[g] SHALL be asserted combinationally in that cycle; all other bits SHALL be 0.
REQ-017 On a grant, the output register SHALL load out_data <= in_dout slice g, out_src <= g and out_valid <= 1 at the next edge; latency from pop to output is exactly 1 cycle.
REQ-018 in_rd_en SHALL be all zero when srst is high, when load_en is low, or when all sources are empty.
REQ-019 If load_en is high and no source is non-empty, out_valid SHALL go to 0 at the next edge; out_data and out_src SHALL hold their values.
REQ-020 If load_en is low (out_valid=1 and out_ready=0), out_valid, out_data and out_src SHALL hold and no pop SHALL occur.
REQ-021 With out_ready held high and any source non-empty every cycle, throughput SHALL be 1 word per cycle with no bubbles.
REQ-022 State ptr [SW-1:0] and burst_cnt [7:0] SHALL update only on a grant, as follows:
REQ-023 - newcnt = (g == ptr) ? burst_cnt + 1 : 1.
REQ-024 - If newcnt == MAX_BURST, then ptr <= (g + 1) mod NUM_SRC and burst_cnt <= 0.
REQ-025 - Otherwise, ptr <= g and burst_cnt <= newcnt.
REQ-026 Wrap-around: ptr = NUM_SRC-1 SHALL advance to 0, and ptr SHALL never hold a value >= NUM_SRC.
REQ-027 A source going empty mid-burst SHALL forfeit its remaining burst; the next grant goes to the next non-empty source in search order, per REQ-023 to REQ-025.
REQ-028 Starvation bound: a continuously non-empty source SHALL be granted within (NUM_SRC-1)*MAX_BURST grants.
REQ-029 Exactly one word SHALL be popped per grant; words SHALL be neither duplicated nor dropped, and per-source order SHALL be preserved.

Reset
REQ-030 While srst is high at a posedge, the block SHALL set out_valid=0, out_data=0, out_src=0, ptr=0 and burst_cnt=0.
REQ-031 srst asserted mid-operation SHALL discard any word held in the output register, with no pop in that cycle.
REQ-032 The first grant after srst deasserts SHALL search from index 0.

Verification
REQ-033 Reset: srst=1 with all sources non-empty -> in_rd_en=0; after the edge out_valid=0, out_data=0, out_src=0.
REQ-034 Round-robin (NUM_SRC=4, MAX_BURST=1): all 4 sources full, out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, with no gaps.
REQ-035 Burst (MAX_BURST=3): sources 0 and 2 non-empty, out_ready=1 -> out_src sequence 0,0,0,2,2,2,0.
REQ-036 Backpressure: out_valid=1 with data 0xA5, out_ready=0 for 5 cycles -> out_data holds 0xA5 and in_rd_en=0 throughout; out_ready=1 -> next word loads 1 cycle later.
REQ-037 Empty and skip: only source 3 non-empty with ptr=1 -> grant g=3, next ptr=0; all sources empty -> out_valid drops after the current word is accepted.
REQ-038 Scoreboard (NUM_SRC=3, non-power-of-2): random empties and random out_ready over 10k cycles -> every popped word appears exactly once, per-source order is preserved, and REQ-028 holds.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Merges NUM_SRC first-word-fall-through FIFOs into one registered stream.
// Arbitration is round-robin, and a source may keep up to MAX_BURST consecutive grants.

module fifo_rr_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 1,
    localparam int SW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [NUM_SRC-1:0]       in_empty,
    input  logic [NUM_SRC*WIDTH-1:0] in_dout,
    output logic [NUM_SRC-1:0]       in_rd_en,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [SW-1:0]            out_src,
    input  logic                     out_ready
);

    localparam logic [7:0]    BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [SW-1:0] LAST_SRC    = SW'(NUM_SRC - 1);
    localparam logic [SW:0]   SRC_COUNT   = (SW + 1)'(NUM_SRC);

    logic              outValid_q, outValid_d;
    logic [WIDTH-1:0]  outData_q,  outData_d;
    logic [SW-1:0]     outSrc_q,   outSrc_d;
    logic [SW-1:0]     ptr_q,      ptr_d;
    logic [7:0]        burstCnt_q, burstCnt_d;

    logic              loadEn;
    logic              found;
    logic              grant;
    logic [SW-1:0]     grantIdx;
    logic [SW:0]       searchIdx;
    logic [WIDTH-1:0]  grantData;
    logic [7:0]        newCnt;

    assign loadEn = !outValid_q || out_ready;
    assign grant  = !srst && loadEn && found;

    // The search index is one bit wider so ptr + offset can be folded back below NUM_SRC.
    always_comb begin
        found     = 1'b0;
        grantIdx  = '0;
        searchIdx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            searchIdx = {1'b0, ptr_q} + (SW + 1)'(k);
            if (searchIdx >= SRC_COUNT) begin
                searchIdx = searchIdx - SRC_COUNT;
            end
            if (!found && !in_empty[searchIdx[SW-1:0]]) begin
                found    = 1'b1;
                grantIdx = searchIdx[SW-1:0];
            end
        end
    end

    always_comb begin
        in_rd_en  = '0;
        grantData = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grantIdx == SW'(i)) begin
                in_rd_en[i] = grant;
                grantData   = in_dout[i*WIDTH +: WIDTH];
            end
        end
    end

    // A grant to anyone other than ptr starts a fresh burst, so a source that ran dry forfeits its remainder.
    always_comb begin
        ptr_d      = ptr_q;
        burstCnt_d = burstCnt_q;
        newCnt     = (grantIdx == ptr_q) ? burstCnt_q + 8'd1 : 8'd1;
        if (grant) begin
            if (newCnt == BURST_LIMIT) begin
                ptr_d      = (grantIdx == LAST_SRC) ? '0 : grantIdx + SW'(1);
                burstCnt_d = '0;
            end else begin
                ptr_d      = grantIdx;
                burstCnt_d = newCnt;
            end
        end
    end

    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSrc_d   = outSrc_q;
        if (loadEn) begin
            outValid_d = found;
            if (found) begin
                outData_d = grantData;
                outSrc_d  = grantIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= '0;
            ptr_q      <= '0;
            burstCnt_q <= '0;
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
            ptr_q      <= ptr_d;
            burstCnt_q <= burstCnt_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_src   = outSrc_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed and randomized checks for fifo_rr_arbiter using three configurations.
// Each source is modelled as an FWFT FIFO whose head word is {src, 0xA5 + words popped so far}.

module tb_fifo_rr_arbiter;

    localparam int W = 16;

    logic clk = 1'b0;
    logic srst;
    int   checkCount = 0;
    int   passCount  = 0;

    always #5 clk = ~clk;

    logic [3:0]   emptyA, rdEnA;
    logic [4*W-1:0] doutA;
    logic         validA, readyA;
    logic [W-1:0] dataA;
    logic [1:0]   srcA;
    logic [11:0]  seqA [4];

    logic [3:0]   emptyB, rdEnB;
    logic [4*W-1:0] doutB;
    logic         validB, readyB;
    logic [W-1:0] dataB;
    logic [1:0]   srcB;
    logic [11:0]  seqB [4];

    logic [2:0]   emptyC, rdEnC;
    logic [3*W-1:0] doutC;
    logic         validC, readyC;
    logic [W-1:0] dataC;
    logic [1:0]   srcC;
    logic [11:0]  seqC [3];

    fifo_rr_arbiter #(.NUM_SRC(4), .WIDTH(W), .MAX_BURST(1)) dutA (
        .clk(clk), .srst(srst), .in_empty(emptyA), .in_dout(doutA), .in_rd_en(rdEnA),
        .out_valid(validA), .out_data(dataA), .out_src(srcA), .out_ready(readyA)
    );

    fifo_rr_arbiter #(.NUM_SRC(4), .WIDTH(W), .MAX_BURST(3)) dutB (
        .clk(clk), .srst(srst), .in_empty(emptyB), .in_dout(doutB), .in_rd_en(rdEnB),
        .out_valid(validB), .out_data(dataB), .out_src(srcB), .out_ready(readyB)
    );

    fifo_rr_arbiter #(.NUM_SRC(3), .WIDTH(W), .MAX_BURST(2)) dutC (
        .clk(clk), .srst(srst), .in_empty(emptyC), .in_dout(doutC), .in_rd_en(rdEnC),
        .out_valid(validC), .out_data(dataC), .out_src(srcC), .out_ready(readyC)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            doutA[i*W +: W] = {4'(i), 12'h0A5 + seqA[i]};
            doutB[i*W +: W] = {4'(i), 12'h0A5 + seqB[i]};
        end
        for (int i = 0; i < 3; i++) begin
            doutC[i*W +: W] = {4'(i), 12'h0A5 + seqC[i]};
        end
    end

    // Source FIFO models: a pop advances that source's head word.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (srst) begin
                seqA[i] <= '0;
                seqB[i] <= '0;
            end else begin
                if (rdEnA[i]) seqA[i] <= seqA[i] + 12'd1;
                if (rdEnB[i]) seqB[i] <= seqB[i] + 12'd1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (srst) seqC[i] <= '0;
            else if (rdEnC[i]) seqC[i] <= seqC[i] + 12'd1;
        end
    end

    task automatic doReset();
        @(negedge clk);
        srst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        emptyA = 4'b0000;
        readyA = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        srst = 1'b1;
        #1;
        checkCount++;
        if (rdEnA !== 4'b0000) $display("[TB] FAIL reset_rd_en: got %b expected 0000", rdEnA);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (validA !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", validA);
        else passCount++;
        checkCount++;
        if (dataA !== 16'h0000) $display("[TB] FAIL reset_data: got %h expected 0000", dataA);
        else passCount++;
        checkCount++;
        if (srcA !== 2'd0) $display("[TB] FAIL reset_src: got %0d expected 0", srcA);
        else passCount++;
        srst = 1'b0;
        #1;
        checkCount++;
        if (rdEnA !== 4'b0001) $display("[TB] FAIL reset_first_grant: got %b expected 0001", rdEnA);
        else passCount++;
    endtask

    task automatic test_round_robin();
        int expSrc [6] = '{0, 1, 2, 3, 0, 1};
        logic [W-1:0] expData [6] = '{16'h00A5, 16'h10A5, 16'h20A5, 16'h30A5, 16'h00A6, 16'h10A6};
        doReset();
        emptyA = 4'b0000;
        readyA = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkCount++;
            if (validA !== 1'b1 || srcA !== 2'(expSrc[k]) || dataA !== expData[k])
                $display("[TB] FAIL round_robin[%0d]: got valid=%b src=%0d data=%h expected valid=1 src=%0d data=%h",
                         k, validA, srcA, dataA, expSrc[k], expData[k]);
            else passCount++;
        end
    endtask

    task automatic test_backpressure();
        doReset();
        emptyA = 4'b1110;
        readyA = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checkCount++;
            if (validA !== 1'b1 || dataA !== 16'h00A5 || rdEnA !== 4'b0000)
                $display("[TB] FAIL backpressure_hold[%0d]: got valid=%b data=%h rd_en=%b expected valid=1 data=00a5 rd_en=0000",
                         k, validA, dataA, rdEnA);
            else passCount++;
            @(negedge clk);
        end
        readyA = 1'b1;
        #1;
        checkCount++;
        if (rdEnA !== 4'b0001) $display("[TB] FAIL backpressure_release_pop: got %b expected 0001", rdEnA);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (validA !== 1'b1 || dataA !== 16'h00A6)
            $display("[TB] FAIL backpressure_next_word: got valid=%b data=%h expected valid=1 data=00a6", validA, dataA);
        else passCount++;
    endtask

    task automatic test_empty_skip();
        doReset();
        emptyA = 4'b1110;
        readyA = 1'b1;
        @(negedge clk);
        emptyA = 4'b0111;
        #1;
        checkCount++;
        if (rdEnA !== 4'b1000) $display("[TB] FAIL skip_grant: got %b expected 1000", rdEnA);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (srcA !== 2'd3 || dataA !== 16'h30A5)
            $display("[TB] FAIL skip_output: got src=%0d data=%h expected src=3 data=30a5", srcA, dataA);
        else passCount++;
        emptyA = 4'b0000;
        #1;
        checkCount++;
        if (rdEnA !== 4'b0001) $display("[TB] FAIL skip_ptr_wrap: got %b expected 0001", rdEnA);
        else passCount++;
        emptyA = 4'b1111;
        readyA = 1'b0;
        #1;
        checkCount++;
        if (rdEnA !== 4'b0000) $display("[TB] FAIL all_empty_rd_en: got %b expected 0000", rdEnA);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (validA !== 1'b1 || srcA !== 2'd3)
            $display("[TB] FAIL all_empty_hold: got valid=%b src=%0d expected valid=1 src=3", validA, srcA);
        else passCount++;
        readyA = 1'b1;
        @(negedge clk);
        checkCount++;
        if (validA !== 1'b0 || srcA !== 2'd3 || dataA !== 16'h30A5)
            $display("[TB] FAIL all_empty_drain: got valid=%b src=%0d data=%h expected valid=0 src=3 data=30a5",
                     validA, srcA, dataA);
        else passCount++;
    endtask

    task automatic test_burst();
        int expSrc [7] = '{0, 0, 0, 2, 2, 2, 0};
        logic [W-1:0] expData [7] = '{16'h00A5, 16'h00A6, 16'h00A7, 16'h20A5, 16'h20A6, 16'h20A7, 16'h00A8};
        doReset();
        emptyB = 4'b1010;
        readyB = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checkCount++;
            if (validB !== 1'b1 || srcB !== 2'(expSrc[k]) || dataB !== expData[k])
                $display("[TB] FAIL burst[%0d]: got valid=%b src=%0d data=%h expected valid=1 src=%0d data=%h",
                         k, validB, srcB, dataB, expSrc[k], expData[k]);
            else passCount++;
        end
        emptyB = 4'b1111;
    endtask

    // Random empties and backpressure on a 3-source, burst-2 instance; bound is (3-1)*2 = 4.
    task automatic test_scoreboard();
        int expC [3] = '{0, 0, 0};
        int waitC [3] = '{0, 0, 0};
        logic expectGrant;
        logic [W-1:0] expData;
        doReset();
        for (int c = 0; c < 10010; c++) begin
            @(negedge clk);
            if (c < 10000) begin
                emptyC = 3'($urandom_range(0, 7));
                readyC = ($urandom_range(0, 3) != 0);
            end else begin
                emptyC = 3'b111;
                readyC = 1'b1;
            end
            #1;
            if (validC && readyC) begin
                checkCount++;
                if (srcC > 2'd2) begin
                    $display("[TB] FAIL sb_src_range: got %0d expected <=2", srcC);
                end else begin
                    expData = {4'(srcC), 12'h0A5 + 12'(expC[srcC])};
                    if (dataC !== expData)
                        $display("[TB] FAIL sb_data cycle %0d: got %h expected %h", c, dataC, expData);
                    else passCount++;
                    expC[srcC]++;
                end
            end
            expectGrant = !(validC && !readyC) && (emptyC != 3'b111);
            checkCount++;
            if ((rdEnC != 3'b000) !== expectGrant || $countones(rdEnC) > 1 || (rdEnC & emptyC) != 3'b000)
                $display("[TB] FAIL sb_rd_en cycle %0d: got %b expected grant=%b from non-empty %b",
                         c, rdEnC, expectGrant, ~emptyC);
            else passCount++;
            for (int i = 0; i < 3; i++) begin
                if (emptyC[i]) waitC[i] = 0;
            end
            if (rdEnC != 3'b000) begin
                for (int i = 0; i < 3; i++) begin
                    if (rdEnC[i]) waitC[i] = 0;
                    else if (!emptyC[i]) waitC[i]++;
                    checkCount++;
                    if (waitC[i] > 4) $display("[TB] FAIL sb_starvation src %0d: got %0d grants waited expected <=4", i, waitC[i]);
                    else passCount++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checkCount++;
            if (int'(seqC[i]) !== expC[i])
                $display("[TB] FAIL sb_count src %0d: got %0d delivered expected %0d popped", i, expC[i], int'(seqC[i]));
            else passCount++;
        end
        checkCount++;
        if (validC !== 1'b0) $display("[TB] FAIL sb_drained: got valid=%b expected 0", validC);
        else passCount++;
    endtask

    initial begin
        srst   = 1'b1;
        emptyA = 4'b1111;
        emptyB = 4'b1111;
        emptyC = 3'b111;
        readyA = 1'b0;
        readyB = 1'b0;
        readyC = 1'b0;
        doReset();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_empty_skip();
        test_burst();
        test_scoreboard();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
